// File: rtl/sio_pkg.sv
// Shared definitions for the simple I/O block arbiter: FSM states, requester IDs
// and the register map of the I/O block.
package sio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } sio_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_MON = 1'b1;

  // Register map; reading SIO_TMODE clears the timer IRQ flag.
  localparam logic [3:0] SIO_LEDS  = 4'h0;
  localparam logic [3:0] SIO_7HI   = 4'h1;
  localparam logic [3:0] SIO_7LO   = 4'h2;
  localparam logic [3:0] SIO_RGB   = 4'h3;
  localparam logic [3:0] SIO_SWKEY = 4'h4;
  localparam logic [3:0] SIO_TMODE = 4'h8;
  localparam logic [3:0] SIO_TPS2  = 4'h9;
  localparam logic [3:0] SIO_TPS1  = 4'hA;
  localparam logic [3:0] SIO_TPS0  = 4'hB;

endpackage

// File: rtl/sio_rr_pick.sv
// Two-way grant selection: lock continuation with a bounded run length,
// otherwise round-robin or fixed priority.
module sio_rr_pick
  import sio_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int LOCK_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       lockHeld_i,
  input  logic       update_i,
  output logic       grant_o
);

  localparam logic [4:0] LockMaxW = 5'(LOCK_MAX);

  logic [3:0] lockCnt_q, lockCnt_d;
  logic       other, regrant, forced;

  // lockCnt_q counts locked re-grants in the current run, so a run holds
  // LOCK_MAX grants in total before the waiting requester is let in.
  always_comb begin
    other     = ~last_i;
    regrant   = lockHeld_i && req_i[last_i];
    forced    = regrant && req_i[other] && (({1'b0, lockCnt_q} + 5'd1) >= LockMaxW);
    grant_o   = REQ_CPU;
    lockCnt_d = '0;
    if (regrant && !forced) begin
      grant_o   = last_i;
      lockCnt_d = (lockCnt_q == 4'hF) ? lockCnt_q : lockCnt_q + 4'd1;
    end else if (forced) begin
      grant_o = other;
    end else if (&req_i) begin
      grant_o = RR_EN ? other : REQ_CPU;
    end else begin
      grant_o = req_i[REQ_MON] ? REQ_MON : REQ_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lockCnt_q <= '0;
    end else if (update_i) begin
      lockCnt_q <= lockCnt_d;
    end
  end

endmodule

// File: rtl/sio_bus_arbiter.sv
// Serialises CPU-bridge and debug-monitor accesses onto the single I/O block
// register port, one chip-select cycle per access.
module sio_bus_arbiter
  import sio_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  lock,
  input  logic [1:0]  rw,
  input  logic [7:0]  ad,
  input  logic [15:0] wdata,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        sio_cs,
  output logic        sio_rw,
  output logic [3:0]  sio_ad,
  output logic [7:0]  sio_di,
  input  logic [7:0]  sio_do
);

  sio_state_e state_q, state_d;
  logic       grant_q, last_q, lockHeld_q;
  logic       sioCs_q, sioRw_q;
  logic [3:0] sioAd_q;
  logic [7:0] sioDi_q, rdata_q;
  logic [1:0] ack_q;
  logic       pickGrant, start, capture, finish;

  sio_rr_pick #(
    .RR_EN   (RR_EN),
    .LOCK_MAX(LOCK_MAX)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .last_i    (last_q),
    .lockHeld_i(lockHeld_q),
    .update_i  (start),
    .grant_o   (pickGrant)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          start   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: begin
        capture = 1'b1;
        state_d = ACK;
      end
      ACK: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Requester inputs are latched only when a transaction starts; the lock bit
  // is sampled at ACK to decide whether the next IDLE may re-grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= REQ_CPU;
      last_q     <= REQ_MON;
      lockHeld_q <= 1'b0;
      sioCs_q    <= 1'b0;
      sioRw_q    <= 1'b1;
      sioAd_q    <= '0;
      sioDi_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
    end else begin
      state_q <= state_d;
      sioCs_q <= start;
      ack_q   <= '0;
      if (start) begin
        grant_q <= pickGrant;
        last_q  <= pickGrant;
        sioRw_q <= rw[pickGrant];
        sioAd_q <= ad[{pickGrant, 2'b00} +: 4];
        sioDi_q <= wdata[{pickGrant, 3'b000} +: 8];
      end
      if (capture) begin
        if (sioRw_q) rdata_q <= sio_do;
        ack_q[grant_q] <= 1'b1;
      end
      if (finish) lockHeld_q <= lock[grant_q];
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = (state_q != IDLE);
  assign sio_cs = sioCs_q;
  assign sio_rw = sioRw_q;
  assign sio_ad = sioAd_q;
  assign sio_di = sioDi_q;

endmodule

// File: tb/tb_sio_bus_arbiter.sv
// Directed bench for sio_bus_arbiter: three instances (RR/lock 4, fixed priority,
// RR/lock 2) share one stimulus set, steered to one instance at a time by sel.
module tb_sio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, rw;
  logic [7:0]  ad;
  logic [15:0] wdata;
  logic [1:0]  sel;
  logic [7:0]  sio_do = 8'h00;

  logic [1:0] reqI   [3];
  logic [1:0] ackI   [3];
  logic [7:0] rdataI [3];
  logic       busyI  [3];
  logic       csI    [3];
  logic       rwI    [3];
  logic [3:0] adI    [3];
  logic [7:0] diI    [3];

  int checks = 0;
  int errors = 0;

  int         csCount    = 0;
  int         irqClears  = 0;
  logic       irqFlag    = 1'b1;
  logic [7:0] lastWrDi   = 8'h00;

  always #5 clk = ~clk;

  assign reqI[0] = (sel == 2'd0) ? req : 2'b00;
  assign reqI[1] = (sel == 2'd1) ? req : 2'b00;
  assign reqI[2] = (sel == 2'd2) ? req : 2'b00;

  sio_bus_arbiter #(.RR_EN(1'b1), .LOCK_MAX(4)) dutA (
    .clk(clk), .rst(rst), .req(reqI[0]), .lock(lock), .rw(rw), .ad(ad), .wdata(wdata),
    .ack(ackI[0]), .rdata(rdataI[0]), .busy(busyI[0]), .sio_cs(csI[0]), .sio_rw(rwI[0]),
    .sio_ad(adI[0]), .sio_di(diI[0]), .sio_do(sio_do));

  sio_bus_arbiter #(.RR_EN(1'b0), .LOCK_MAX(4)) dutB (
    .clk(clk), .rst(rst), .req(reqI[1]), .lock(lock), .rw(rw), .ad(ad), .wdata(wdata),
    .ack(ackI[1]), .rdata(rdataI[1]), .busy(busyI[1]), .sio_cs(csI[1]), .sio_rw(rwI[1]),
    .sio_ad(adI[1]), .sio_di(diI[1]), .sio_do(sio_do));

  sio_bus_arbiter #(.RR_EN(1'b1), .LOCK_MAX(2)) dutC (
    .clk(clk), .rst(rst), .req(reqI[2]), .lock(lock), .rw(rw), .ad(ad), .wdata(wdata),
    .ack(ackI[2]), .rdata(rdataI[2]), .busy(busyI[2]), .sio_cs(csI[2]), .sio_rw(rwI[2]),
    .sio_ad(adI[2]), .sio_di(diI[2]), .sio_do(sio_do));

  logic [1:0] ackSel;
  logic [7:0] rdataSel, diSel;
  logic [3:0] adSel;
  logic       busySel, csSel, rwSel;

  assign ackSel   = ackI[sel];
  assign rdataSel = rdataI[sel];
  assign busySel  = busyI[sel];
  assign csSel    = csI[sel];
  assign rwSel    = rwI[sel];
  assign adSel    = adI[sel];
  assign diSel    = diI[sel];

  // I/O block model: registered read data, timer-mode read clears the IRQ flag.
  always @(posedge clk) begin
    if (csSel) begin
      csCount <= csCount + 1;
      if (rwSel) begin
        case (adSel)
          4'h4:    sio_do <= 8'h3C;
          4'h8:    sio_do <= {7'h40, irqFlag};
          4'h9:    sio_do <= 8'h91;
          4'hA:    sio_do <= 8'hA2;
          4'hB:    sio_do <= 8'hB3;
          default: sio_do <= 8'hEE;
        endcase
        if (adSel == 4'h8 && irqFlag) begin
          irqFlag   <= 1'b0;
          irqClears <= irqClears + 1;
        end
      end else begin
        lastWrDi <= diSel;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic waitAck(output logic [1:0] a, output int cycles);
    cycles = 0;
    a      = 2'b00;
    do begin
      tick();
      cycles++;
      a = ackSel;
    end while (a == 2'b00 && cycles < 20);
    if (a == 2'b00) checkOutput("ackTimeout", 32'(cycles), 32'd0);
  endtask

  // Runs four grants on the selected instance and records the winner of each.
  // In lock mode requester 0 drops out after three accesses and requester 1 after one.
  task automatic applyStimulus(input logic lockRun, output logic [3:0] seq);
    logic [1:0] a;
    int         cy;
    int         n0;
    n0    = 0;
    seq   = 4'h0;
    rw    = 2'b11;
    ad    = {4'h4, 4'h9};
    lock  = lockRun ? 2'b01 : 2'b00;
    req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      waitAck(a, cy);
      seq[k] = a[1];
      if (lockRun) begin
        if (a[0]) begin
          n0++;
          ad[3:0] = 4'h9 + 4'(n0);
          if (n0 == 3) req[0] = 1'b0;
        end
        if (a[1]) req[1] = 1'b0;
      end
    end
    req  = 2'b00;
    lock = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    logic [1:0] a;
    logic [3:0] seq;
    int         cy;
    int         c0;

    rst = 1'b0; req = 2'b00; lock = 2'b00; rw = 2'b00; ad = 8'h00; wdata = 16'h0000;
    sel = 2'd0;
    repeat (3) tick();
    checkOutput("rst_ack",   {30'd0, ackSel}, 32'd0);
    checkOutput("rst_rdata", {24'd0, rdataSel}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busySel}, 32'd0);
    checkOutput("rst_cs",    {31'd0, csSel}, 32'd0);
    checkOutput("rst_rw",    {31'd0, rwSel}, 32'd1);
    checkOutput("rst_ad",    {28'd0, adSel}, 32'd0);
    checkOutput("rst_di",    {24'd0, diSel}, 32'd0);
    rst = 1'b1;
    tick();

    // single write from requester 0
    rw = 2'b00; ad = 8'h00; wdata = 16'h00A5; req = 2'b01; c0 = csCount;
    tick();
    checkOutput("t1_cs",   {31'd0, csSel}, 32'd1);
    checkOutput("t1_ad",   {28'd0, adSel}, 32'd0);
    checkOutput("t1_di",   {24'd0, diSel}, 32'hA5);
    checkOutput("t1_rw",   {31'd0, rwSel}, 32'd0);
    checkOutput("t1_busy", {31'd0, busySel}, 32'd1);
    tick();
    checkOutput("t1_csLow", {31'd0, csSel}, 32'd0);
    tick();
    checkOutput("t1_ack", {30'd0, ackSel}, 32'b01);
    req = 2'b00;
    tick();
    checkOutput("t1_ackOnce", {30'd0, ackSel}, 32'd0);
    checkOutput("t1_idle",    {31'd0, busySel}, 32'd0);
    checkOutput("t1_csCount", 32'(csCount - c0), 32'd1);
    checkOutput("t1_wdata",   {24'd0, lastWrDi}, 32'hA5);

    // single read from requester 1
    rw = 2'b10; ad = 8'h40; wdata = 16'h0000; req = 2'b10; c0 = csCount;
    waitAck(a, cy);
    checkOutput("t2_latency", 32'(cy), 32'd3);
    checkOutput("t2_ack",     {30'd0, a}, 32'b10);
    checkOutput("t2_rdata",   {24'd0, rdataSel}, 32'h3C);
    req = 2'b00;
    tick();
    checkOutput("t2_csCount", 32'(csCount - c0), 32'd1);
    checkOutput("t2_rdHold",  {24'd0, rdataSel}, 32'h3C);
    tick();

    // contention without lock
    applyStimulus(1'b0, seq);
    checkOutput("t3_rrSeq", {28'd0, seq}, 32'b1010);
    sel = 2'd1;
    applyStimulus(1'b0, seq);
    checkOutput("t3_fixedSeq", {28'd0, seq}, 32'b0000);

    // locked multi-byte runs, LOCK_MAX 4 and 2
    sel = 2'd0;
    applyStimulus(1'b1, seq);
    checkOutput("t4_lock4Seq", {28'd0, seq}, 32'b1000);
    sel = 2'd2;
    applyStimulus(1'b1, seq);
    checkOutput("t4_lock2Seq", {28'd0, seq}, 32'b0100);

    // requester drops req mid-transaction; timer-mode read still completes once
    sel = 2'd0;
    rw = 2'b01; ad = 8'h08; req = 2'b01; c0 = csCount;
    tick();
    tick();
    req = 2'b00;
    tick();
    checkOutput("t5_ack",   {30'd0, ackSel}, 32'b01);
    checkOutput("t5_rdata", {24'd0, rdataSel}, 32'h81);
    tick();
    checkOutput("t5_irqClears", 32'(irqClears), 32'd1);
    checkOutput("t5_irqFlag",   {31'd0, irqFlag}, 32'd0);
    checkOutput("t5_csCount",   32'(csCount - c0), 32'd1);
    checkOutput("t5_idle",      {31'd0, busySel}, 32'd0);

    // reset asserted during ACCESS, then a fresh request
    rw = 2'b00; ad = 8'h00; wdata = 16'h0011; req = 2'b01; c0 = csCount;
    tick();
    checkOutput("t6_csBefore", {31'd0, csSel}, 32'd1);
    rst = 1'b0;
    tick();
    checkOutput("t6_cs",   {31'd0, csSel}, 32'd0);
    checkOutput("t6_busy", {31'd0, busySel}, 32'd0);
    checkOutput("t6_ack",  {30'd0, ackSel}, 32'd0);
    tick();
    checkOutput("t6_ackHeld", {30'd0, ackSel}, 32'd0);
    rst = 1'b1;
    waitAck(a, cy);
    checkOutput("t6_latency", 32'(cy), 32'd3);
    checkOutput("t6_ackNew",  {30'd0, a}, 32'b01);
    req = 2'b00;
    tick();
    checkOutput("t6_csCount", 32'(csCount - c0), 32'd2);
    checkOutput("t6_wdata",   {24'd0, lastWrDi}, 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
